// File: rtl/pipelined_addsub_if.sv
// -----------------------------------------------------------------------------
// pipelined_addsub_if
//
// Purpose:
//    Bundles the operand-side and result-side valid/ready handshakes of
//    pipelined_addsub into one interface.
//
// Signals:
//    in_valid   operand beat valid                    (master -> slave)
//    in_ready   block can accept a beat this cycle    (slave  -> master)
//    a, b       operands, DATA_WIDTH bits             (master -> slave)
//    cin        carry-in (add) / borrow-in (sub)      (master -> slave)
//    sub        0: a+b+cin, 1: a-b-cin                (master -> slave)
//    out_valid  result beat valid                     (slave  -> master)
//    out_ready  consumer accepts result this cycle    (master -> slave)
//    sum        result, DATA_WIDTH bits               (slave  -> master)
//    cout       chain carry-out (sub: 1 = no borrow)  (slave  -> master)
//    ovf        signed two's-complement overflow      (slave  -> master)
//
// Modports:
//    master  the side that supplies operands and consumes results
//    slave   the adder itself
// -----------------------------------------------------------------------------
interface pipelined_addsub_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] b;
   logic                  cin;
   logic                  sub;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] sum;
   logic                  cout;
   logic                  ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pipelined_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_addsub
//
// Purpose:
//    Pipelined adder/subtractor. The DATA_WIDTH carry chain is cut into
//    STAGES chunks of CW = DATA_WIDTH/STAGES bits; stage k adds chunk k using
//    the carry registered by stage k-1, so each stage is a CW-bit adder.
//    Subtraction is done as a + ~b + ~cin. One result per clock, latency of
//    exactly STAGES cycles when the consumer never stalls.
//
// Parameters:
//    DATA_WIDTH  operand/result width (must be divisible by STAGES)
//    STAGES      number of register stages (1 = single registered adder)
//
// Ports:
//    clk    sole clock, rising edge
//    rst_n  asynchronous active-low reset; flushes every in-flight beat
//    bus    pipelined_addsub_if.slave: in_valid/in_ready/a/b/cin/sub on the
//           operand side, out_valid/out_ready/sum/cout/ovf on the result side
//
// Configuration:
//    PIPELINED_ADDSUB_SAT_EN  when defined, the last stage clamps sum to the
//                             largest positive / most negative value on
//                             signed overflow (cout and ovf unchanged).
//                             Undefined: sum is the raw wrapped result.
//
// Flow control:
//    Stage k loads when it is empty or when its contents move on this cycle
//    (stage k+1 loads, or for the last stage the result is accepted). This
//    collapses bubbles and gives in_ready = stage 0 may load, which is a
//    combinational function of out_ready through the ready chain.
// -----------------------------------------------------------------------------
module pipelined_addsub #(
   parameter int DATA_WIDTH = 16,
   parameter int STAGES     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   pipelined_addsub_if.slave bus
);

   localparam int CW  = DATA_WIDTH / STAGES;
   localparam int MSB = DATA_WIDTH - 1;

   typedef logic [DATA_WIDTH-1:0] word_t;

   // Everything a beat carries down the pipe. Full operands travel along so
   // later stages can pick their chunk; res fills in chunk by chunk.
   typedef struct packed {
      word_t a;      // operand A
      word_t bx;     // operand B, already inverted in sub mode
      word_t res;    // result chunks computed so far
      logic  carry;  // carry out of the most recent chunk
      logic  ovf;    // signed overflow, meaningful in the last stage only
   } beat_t;

`ifdef PIPELINED_ADDSUB_SAT_EN
   localparam word_t SAT_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam word_t SAT_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

   beat_t               stage_q [STAGES];  // per-stage beat registers
   logic [STAGES-1:0]   valid_q;           // per-stage occupancy
   beat_t               src     [STAGES];  // beat presented to stage k
   beat_t               stage_d [STAGES];  // stage k's value after its add
   logic [STAGES-1:0]   vin;               // valid presented to stage k
   logic [STAGES:0]     en;                // stage k may load this cycle
   logic [CW:0]         chunk_sum;

   // --------------------------------------------------------------------------
   // Ready chain, per-stage sources and per-stage chunk adders
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default before any branch or
      // loop touches it, so no latch can be inferred.
      en        = '0;
      vin       = '0;
      chunk_sum = '0;
      for (int k = 0; k < STAGES; k++) begin
         src[k]     = '0;
         stage_d[k] = '0;
      end

      // Walk from the output back to the input: a stage can load if it is
      // empty or its occupant leaves this cycle.
      en[STAGES] = bus.out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         en[k] = !valid_q[k] || en[k+1];
      end

      // Stage 0 sees the raw operands, with B and the carry-in inverted in
      // sub mode; every later stage sees its predecessor's register.
      vin[0]       = bus.in_valid;
      src[0].a     = bus.a;
      src[0].bx    = bus.sub ? ~bus.b : bus.b;
      src[0].res   = '0;
      src[0].carry = bus.cin ^ bus.sub;
      src[0].ovf   = 1'b0;
      for (int k = 1; k < STAGES; k++) begin
         vin[k] = valid_q[k-1];
         src[k] = stage_q[k-1];
      end

      // Each stage adds its own CW-bit chunk and passes the carry on.
      for (int k = 0; k < STAGES; k++) begin
         chunk_sum = {1'b0, src[k].a[k*CW +: CW]}
                   + {1'b0, src[k].bx[k*CW +: CW]}
                   + {{CW{1'b0}}, src[k].carry};
         stage_d[k]                 = src[k];
         stage_d[k].res[k*CW +: CW] = chunk_sum[CW-1:0];
         stage_d[k].carry           = chunk_sum[CW];
      end

      // The last stage has the complete result: overflow when both addends
      // share a sign and the result's sign differs from it.
      stage_d[STAGES-1].ovf =
         (stage_d[STAGES-1].a[MSB] == stage_d[STAGES-1].bx[MSB]) &&
         (stage_d[STAGES-1].res[MSB] != stage_d[STAGES-1].a[MSB]);

`ifdef PIPELINED_ADDSUB_SAT_EN
      // Clamp towards the sign of A, which is also the sign of the true
      // (unwrapped) result whenever overflow occurred.
      if (stage_d[STAGES-1].ovf) begin
         stage_d[STAGES-1].res = stage_d[STAGES-1].a[MSB] ? SAT_NEG : SAT_POS;
      end
`endif
   end

   // --------------------------------------------------------------------------
   // Stage registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         // NOTE: the beat registers are ordinary flops, not a RAM, and they
         // drive sum/cout/ovf directly, so they are reset too; that makes the
         // result outputs read 0 out of reset.
         for (int k = 0; k < STAGES; k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         // NOTE: non-blocking updates let every stage capture its
         // predecessor's pre-edge contents, which is what makes the chain a
         // pipeline rather than a single long combinational path.
         for (int k = 0; k < STAGES; k++) begin
            if (en[k]) begin
               valid_q[k] <= vin[k];
               // Data only moves with a real beat; while a stage is stalled
               // its contents (and so the outputs) hold.
               if (vin[k]) begin
                  stage_q[k] <= stage_d[k];
               end
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign bus.in_ready  = en[0];
   assign bus.out_valid = valid_q[STAGES-1];
   assign bus.sum       = stage_q[STAGES-1].res;
   assign bus.cout      = stage_q[STAGES-1].carry;
   assign bus.ovf       = stage_q[STAGES-1].ovf;

endmodule

// File: tb/tb_pipelined_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipelined_addsub
//
// Self-checking bench for pipelined_addsub (DATA_WIDTH=8, STAGES=4).
// Accepted operand beats push the reference result into a scoreboard queue;
// an independent monitor pops and compares whenever a result is handed over.
// The reference model works on plain integers: unsigned sums/differences for
// sum and cout, signed sums/differences for overflow.
// -----------------------------------------------------------------------------
module tb_pipelined_addsub;

   localparam int DW = 8;
   localparam int ST = 4;

   typedef struct {
      logic [DW-1:0] sum;
      logic          cout;
      logic          ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   pipelined_addsub_if #(.DATA_WIDTH(DW)) bus ();

   pipelined_addsub #(
      .DATA_WIDTH(DW),
      .STAGES    (ST)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   exp_t          sb [$];
   int            n_checks = 0;
   int            n_fail   = 0;
   int            n_in     = 0;
   int            n_out    = 0;
   int            rdy_mode = 0;   // 0: always ready, 1: random, 2: never
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_sum   = '0;
   logic          prev_cout  = 1'b0;
   logic          prev_ovf   = 1'b0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t",
                  name, act, exp, $time);
      end
   endtask

   // Reference: straight integer arithmetic on the operands.
   function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic cin, input logic sub);
      exp_t e;
      int   ua = int'(a);
      int   ub = int'(b);
      int   sa = int'($signed(a));
      int   sbv = int'($signed(b));
      int   ur;
      int   sr;
      ur = sub ? (ua - ub - int'(cin)) : (ua + ub + int'(cin));
      sr = sub ? (sa - sbv - int'(cin)) : (sa + sbv + int'(cin));
      e.sum  = DW'(ur);
      e.cout = sub ? (ur >= 0) : (ur >= 2**DW);
      e.ovf  = (sr > 2**(DW-1) - 1) || (sr < -(2**(DW-1)));
`ifdef PIPELINED_ADDSUB_SAT_EN
      if (e.ovf) e.sum = a[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
      return e;
   endfunction

   // Consumer-side ready generator.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
         endcase
      end
   end

   // Input monitor: every accepted beat queues its expected result.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && bus.in_valid && bus.in_ready)
            sb.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
      end
   end

   // Occupancy tracker: in_ready may only drop when all stages hold a beat
   // and the consumer is stalling.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            n_in  = 0;
            n_out = 0;
         end else begin
            check("in_ready_vs_occupancy", 32'(bus.in_ready),
                  32'(!((n_in - n_out) == ST && !bus.out_ready)));
            if (bus.in_valid && bus.in_ready) n_in++;
            if (bus.out_valid && bus.out_ready) n_out++;
         end
      end
   end

   // Output monitor: compares handed-over results and checks stall stability.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_hold_valid", 32'(bus.out_valid), 32'd1);
               check("stall_hold_sum",   32'(bus.sum),  32'(prev_sum));
               check("stall_hold_cout",  32'(bus.cout), 32'(prev_cout));
               check("stall_hold_ovf",   32'(bus.ovf),  32'(prev_ovf));
            end
            if (bus.out_valid && bus.out_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_output", 32'(bus.out_valid), 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("sb_sum",  32'(bus.sum),  32'(e.sum));
                  check("sb_cout", 32'(bus.cout), 32'(e.cout));
                  check("sb_ovf",  32'(bus.ovf),  32'(e.ovf));
               end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_sum   = bus.sum;
            prev_cout  = bus.cout;
            prev_ovf   = bus.ovf;
         end
      end
   end

   // Present one beat (called just after a rising edge) and hold it until
   // accepted; returns the number of cycles it took.
   task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic cin, input logic sub, output int cycles);
      logic acc = 1'b0;
      bus.a        = a;
      bus.b        = b;
      bus.cin      = cin;
      bus.sub      = sub;
      bus.in_valid = 1'b1;
      cycles       = 0;
      while (!acc && cycles < 200) begin
         @(negedge clk);
         acc = bus.in_ready;
         cycles++;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      check("send_accepted", 32'(acc), 32'd1);
   endtask

   // Single beat into an empty pipe, with latency and exact result checks.
   task automatic directed(input string name, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic cin,
                           input logic sub, input logic [DW-1:0] es,
                           input logic ec, input logic eo);
      int cyc;
      int lat = 0;
      send(a, b, cin, sub, cyc);
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.out_valid && lat < 20);
      check({name, "_latency"}, 32'(lat), 32'(ST));
      check({name, "_sum"},  32'(bus.sum),  32'(es));
      check({name, "_cout"}, 32'(bus.cout), 32'(ec));
      check({name, "_ovf"},  32'(bus.ovf),  32'(eo));
      @(posedge clk);
      #1;
   endtask

   task automatic stream(input int n, output int total);
      int cyc;
      total = 0;
      for (int i = 0; i < n; i++) begin
         send(DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom), cyc);
         total += cyc;
      end
   endtask

   task automatic drain(output int cnt);
      cnt = 0;
      while (sb.size() != 0 && cnt < 500) begin
         @(negedge clk);
         #1;
         cnt++;
      end
      check("drain_empty", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int            cyc;
      int            cnt;
      logic [DW-1:0] sat_pos_case;
      logic [DW-1:0] sat_neg_case;
`ifdef PIPELINED_ADDSUB_SAT_EN
      sat_pos_case = 8'h7F;
      sat_neg_case = 8'h80;
`else
      sat_pos_case = 8'h80;
      sat_neg_case = 8'h7F;
`endif
      bus.in_valid = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
      bus.cin      = 1'b0;
      bus.sub      = 1'b0;

      // Reset state.
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_sum",       32'(bus.sum),       32'd0);
      check("reset_cout",      32'(bus.cout),      32'd0);
      check("reset_ovf",       32'(bus.ovf),       32'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      #1;
      check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Directed boundary cases.
      directed("add_wrap",      8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      directed("add_pos_ovf",   8'h7F, 8'h01, 1'b0, 1'b0, sat_pos_case, 1'b0, 1'b1);
      directed("sub_borrow",    8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
      directed("sub_neg_ovf",   8'h80, 8'h01, 1'b0, 1'b1, sat_neg_case, 1'b1, 1'b1);
      directed("add_cin_chain", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      directed("sub_bin",       8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0);

      // Back-to-back stream with a consumer that never stalls.
      rdy_mode = 0;
      stream(100, cyc);
      check("stream_no_stall_cycles", 32'(cyc), 32'd100);
      drain(cnt);
      check("stream_drain_cycles", 32'(cnt), 32'(ST));

      // Same kind of stream against a randomly stalling consumer.
      rdy_mode = 1;
      @(posedge clk);
      #1;
      stream(100, cyc);
      drain(cnt);
      check("all_beats_delivered", 32'(n_out), 32'(n_in));
      rdy_mode = 0;

      // Reset with beats in flight and the consumer blocked.
      rdy_mode = 2;
      @(posedge clk);
      #2;
      for (int i = 0; i < 3; i++) begin
         send(DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom), cyc);
      end
      repeat (2) @(posedge clk);
      #1;
      check("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_flush_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_flush_sum",       32'(bus.sum),       32'd0);
      sb.delete();
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      directed("post_reset", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      check("no_stale_output", 32'(bus.out_valid), 32'd0);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
